// File: rtl/rs232_tx_sequencer_pkg.sv
// Shared widths and FSM state encoding for the RS-232 transmit sequencer.
package rs232_tx_sequencer_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TMO_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_TX_START  = 3'd2,
    ST_TX_WAIT   = 3'd3,
    ST_DLY_START = 3'd4,
    ST_DLY_WAIT  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/rs232_tx_sequencer_fifo.sv
// Byte FIFO feeding the transmit sequencer; head is read straight from the storage flops.
module rs232_tx_sequencer_fifo
  import rs232_tx_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_n, rd_ptr_n, level_n;
  logic              wr_ok, rd_ok;

  // A write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && (level != '0);
    wr_ptr_n = wr_ptr + PTR_W'(wr_ok);
    rd_ptr_n = rd_ptr + PTR_W'(rd_ok);
    level_n  = wr_ptr_n - rd_ptr_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      level    <= level_n;
      full     <= (level_n == PTR_W'(DEPTH));
      overflow <= overflow | (wr_en && full);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/rs232_tx_sequencer.sv
// Buffers bytes for the UART transmitter and enforces the inter-byte gap via rs232_timer.
module rs232_tx_sequencer
  import rs232_tx_sequencer_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH_LOG2  = 4,
  parameter logic [DATA_W-1:0] EXTRA_DELAY_CHAR = 8'h0D,
  parameter logic [TMO_W-1:0]  TX_TIMEOUT       = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   level,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic                       timer_start,
  output logic                       timer_extra_delay,
  input  logic                       timer_done,
  output logic                       tx_error,
  output logic                       busy,
  output logic [STATE_W-1:0]         state
);

  seq_state_e        st;
  logic              extra;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign pop   = (st == ST_LOAD);
  assign state = st;

  rs232_tx_sequencer_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .overflow (overflow),
    .level    (level)
  );

  // Pulses are set on the transition into the state that owns them, so they coincide with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st                <= ST_IDLE;
      tx_start          <= 1'b0;
      tx_data           <= '0;
      timer_start       <= 1'b0;
      timer_extra_delay <= 1'b0;
      tx_error          <= 1'b0;
      busy              <= 1'b0;
      extra             <= 1'b0;
      tmo_cnt           <= '0;
    end else begin
      tx_start          <= 1'b0;
      timer_start       <= 1'b0;
      timer_extra_delay <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (level != '0) begin
            st   <= ST_LOAD;
            busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          tx_data  <= head;
          extra    <= (head == EXTRA_DELAY_CHAR);
          tx_start <= 1'b1;
          st       <= ST_TX_START;
        end
        ST_TX_START: begin
          tmo_cnt <= '0;
          st      <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (tx_done || (tmo_cnt == TX_TIMEOUT)) begin
            if (!tx_done) tx_error <= 1'b1;
            timer_start       <= 1'b1;
            timer_extra_delay <= extra;
            st                <= ST_DLY_START;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_DLY_START: st <= ST_DLY_WAIT;
        ST_DLY_WAIT: begin
          if (timer_done) begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_sequencer.sv
// Bench for rs232_tx_sequencer with behavioural UART and gap-timer models.
module tb_rs232_tx_sequencer;

  localparam int unsigned DLY    = 20;
  localparam int unsigned XDLY   = 30;
  localparam int unsigned UART_T = 10;
  localparam int unsigned TMO    = 300;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, overflow;
  logic [4:0] level;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       timer_start, timer_extra_delay;
  logic       timer_done = 1'b0;
  logic       tx_error, busy;
  logic [2:0] state;

  rs232_tx_sequencer #(
    .FIFO_DEPTH_LOG2  (4),
    .EXTRA_DELAY_CHAR (8'h0D),
    .TX_TIMEOUT       (16'(TMO))
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .full              (full),
    .overflow          (overflow),
    .level             (level),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .tx_done           (tx_done),
    .timer_start       (timer_start),
    .timer_extra_delay (timer_extra_delay),
    .timer_done        (timer_done),
    .tx_error          (tx_error),
    .busy              (busy),
    .state             (state)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART answers UART_T cycles after tx_start; timer answers DLY (+XDLY) cycles after start.
  bit uart_en = 1'b1;
  int ucnt = 0;
  int tcnt = 0;
  always @(negedge clk) begin
    tx_done    = 1'b0;
    timer_done = 1'b0;
    if (!reset_n) begin
      ucnt = 0;
      tcnt = 0;
    end else begin
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_done = 1'b1;
      end
      if (tcnt > 0) begin
        tcnt--;
        if (tcnt == 0) timer_done = 1'b1;
      end
      if (tx_start && uart_en) ucnt = UART_T;
      if (timer_start) tcnt = timer_extra_delay ? DLY + XDLY : DLY;
    end
  end

  // Reference: bytes leave in write order; a CR byte asks for the extra delay on its gap.
  logic [7:0] expq[$];
  int  starts = 0, tstarts = 0, xstarts = 0;
  int  last_gap = 0, last_start_cyc = 0, done_cyc = 0;
  bit  done_valid = 1'b0, cur_extra = 1'b0, done_extra = 1'b0, last_xd = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (!reset_n) begin
      done_valid = 1'b0;
      cur_extra  = 1'b0;
    end else begin
      if (tx_done) begin
        done_valid = 1'b1;
        done_cyc   = cyc;
        done_extra = cur_extra;
      end
      if (tx_start) begin
        starts++;
        last_start_cyc = cyc;
        if (expq.size() == 0) chk("unexpected_tx_start", 1, 0);
        else begin
          e = expq.pop_front();
          chk("tx_data_order", int'(tx_data), int'(e));
          cur_extra = (e == 8'h0D);
          last_data = tx_data;
        end
        if (done_valid) begin
          last_gap = cyc - done_cyc;
          chk("gap_min", int'(last_gap >= int'(DLY + 3 + (done_extra ? XDLY : 0))), 1);
          done_valid = 1'b0;
        end
      end
      if (timer_start) begin
        tstarts++;
        if (timer_extra_delay) xstarts++;
        last_xd = timer_extra_delay;
        chk("timer_extra_delay", int'(timer_extra_delay), int'(cur_extra));
      end
    end
  end

  task automatic wr1(input logic [7:0] d, input bit acc);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (acc) expq.push_back(d);
  endtask

  task automatic wr_end();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    bit to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && state == 3'd0 && level == 5'd0 && !busy) begin
        to = 1'b0;
        break;
      end
    end
    chk("drain_timeout", int'(to), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b0;
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         exp_extra;
  } vec_t;

  initial begin
    vec_t vt[8];
    int   g_norm, g_cr, x0, s0, t0, ecyc;
    bit   to;
    vt[0] = '{8'h0D, 1'b1};
    vt[1] = '{8'h0A, 1'b0};
    vt[2] = '{8'h8D, 1'b0};
    vt[3] = '{8'h0C, 1'b0};
    vt[4] = '{8'h00, 1'b0};
    vt[5] = '{8'hFF, 1'b0};
    vt[6] = '{8'h0E, 1'b0};
    vt[7] = '{8'h0D, 1'b1};

    // Reset: everything low, writes ignored.
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_timer_start", int'(timer_start), 0);
    chk("rst_timer_xd", int'(timer_extra_delay), 0);
    chk("rst_tx_error", int'(tx_error), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(state), 0);
    wr_en = 1'b0;
    reset_n = 1'b1;

    // Latency from a write into an empty FIFO, then two more bytes.
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h41; expq.push_back(8'h41);
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_level", int'(level), 1);
    chk("lat_state_idle", int'(state), 0);
    @(negedge clk);
    chk("lat_state_load", int'(state), 1);
    chk("lat_no_start", int'(tx_start), 0);
    @(negedge clk);
    chk("lat_tx_start", int'(tx_start), 1);
    chk("lat_tx_data", int'(tx_data), 8'h41);
    wr1(8'h42, 1'b1);
    wr1(8'h43, 1'b1);
    wr_end();
    wait_idle(2000);
    chk("three_starts", starts, 3);

    // Plain gap, then gap after CR.
    x0 = xstarts;
    wr1(8'h41, 1'b1); wr1(8'h42, 1'b1); wr_end();
    wait_idle(2000);
    g_norm = last_gap;
    chk("gap_no_extra", xstarts - x0, 0);
    wr1(8'h0D, 1'b1); wr1(8'h41, 1'b1); wr_end();
    wait_idle(2000);
    g_cr = last_gap;
    chk("gap_cr_growth", g_cr - g_norm, int'(XDLY));
    chk("cr_extra_once", xstarts - x0, 1);

    // Table: single bytes, extra flag and data checked after each one.
    for (int i = 0; i < 8; i++) begin
      wr1(vt[i].data, 1'b1);
      wr_end();
      wait_idle(2000);
      chk("tbl_data", int'(last_data), int'(vt[i].data));
      chk("tbl_extra", int'(last_xd), int'(vt[i].exp_extra));
    end

    // Random traffic, kept below FIFO capacity.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0 && expq.size() < 12) begin
        wr_en   = 1'b1;
        wr_data = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
        expq.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_end();
    wait_idle(10000);
    chk("rand_no_overflow", int'(overflow), 0);
    chk("rand_no_tx_error", int'(tx_error), 0);

    // Overflow with a silent UART.
    uart_en = 1'b0;
    for (int i = 0; i < 17; i++) wr1(8'(i + 1), 1'b1);
    wr_end();
    chk("ovf_full", int'(full), 1);
    chk("ovf_level16", int'(level), 16);
    chk("ovf_not_yet", int'(overflow), 0);
    wr1(8'hEE, 1'b0);
    wr_end();
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_level_hold", int'(level), 16);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_error) begin
        to = 1'b0;
        break;
      end
    end
    chk("ovf_tx_error", int'(to), 0);
    uart_en = 1'b1;
    wait_idle(5000);
    chk("ovf_overflow_stays", int'(overflow), 1);

    // Reset clears sticky flags; then timeout with the UART silent.
    do_reset();
    @(negedge clk);
    chk("rst2_tx_error", int'(tx_error), 0);
    chk("rst2_overflow", int'(overflow), 0);
    uart_en = 1'b0;
    t0 = tstarts;
    wr1(8'h41, 1'b1); wr1(8'h42, 1'b1); wr_end();
    to = 1'b1;
    ecyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_error) begin
        to = 1'b0;
        ecyc = cyc;
        break;
      end
    end
    chk("tmo_seen", int'(to), 0);
    chk("tmo_window", int'((ecyc - last_start_cyc) >= int'(TMO) && (ecyc - last_start_cyc) <= int'(TMO + 4)), 1);
    wait_idle(3000);
    chk("tmo_timer_runs", tstarts - t0, 2);
    chk("tmo_error_sticky", int'(tx_error), 1);
    uart_en = 1'b1;

    // Reset while waiting on the gap timer.
    wr1(8'h41, 1'b1); wr1(8'h42, 1'b1); wr1(8'h43, 1'b1); wr_end();
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (state == 3'd5) begin
        to = 1'b0;
        break;
      end
    end
    chk("dly_wait_reached", int'(to), 0);
    s0 = starts;
    @(negedge clk);
    reset_n = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("dlyrst_state", int'(state), 0);
    chk("dlyrst_level", int'(level), 0);
    chk("dlyrst_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("dlyrst_no_start", starts - s0, 0);
    wr1(8'h44, 1'b1);
    wr_end();
    wait_idle(2000);
    chk("dlyrst_resume", starts - s0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
